// File: rtl/jtgng_rom_arbiter_if.sv
// Bus bundle between the ROM arbiter, its ROM clients and the SDRAM controller read port.
// master = arbiter side, slave = clients plus controller side.
interface jtgng_rom_arbiter_if #(
  parameter int NCLIENT = 4
);
  logic [NCLIENT-1:0]    cl_cs;
  logic [22*NCLIENT-1:0] cl_addr;
  logic [NCLIENT-1:0]    cl_ok;
  logic [32*NCLIENT-1:0] cl_dout;
  logic                  read_sync;
  logic                  read_req;
  logic [21:0]           sdram_addr;
  logic [31:0]           data_read;

  modport master (
    input  cl_cs, cl_addr, data_read,
    output cl_ok, cl_dout, read_sync, read_req, sdram_addr
  );

  modport slave (
    output cl_cs, cl_addr, data_read,
    input  cl_ok, cl_dout, read_sync, read_req, sdram_addr
  );
endinterface

// File: rtl/jtgng_rom_arbiter.sv
// Shares one SDRAM read port among NCLIENT ROM clients, each with a one-word cache,
// and issues refresh strobes whenever no client is waiting.
module jtgng_rom_arbiter #(
  parameter int NCLIENT = 4,
  parameter int LAT     = 9,
  parameter int PERIOD  = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic loop_rst,
  input  logic downloading,
  jtgng_rom_arbiter_if.master bus
);
  localparam int CW = (NCLIENT > 1) ? $clog2(NCLIENT) : 1;
  localparam int TW = (PERIOD > 2) ? $clog2(PERIOD) : 1;
  localparam logic [TW-1:0] T_LOAD  = TW'(PERIOD - 1);
  // Timer value seen during the cycle that ends LAT edges after the toggle.
  localparam logic [TW-1:0] T_LATCH = TW'(PERIOD - LAT);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [CW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cur_q, cur_d;
  logic          read_sync_q, read_sync_d;
  logic          read_req_q, read_req_d;
  logic [21:0]   sdram_addr_q, sdram_addr_d;
  logic          abort_q, abort_d;

  logic          inhibit;
  logic          busy;
  logic          fill;
  logic          any_miss;
  logic [CW-1:0] sel;
  logic [CW-1:0] rr_idx;

  wire [NCLIENT-1:0]    miss_w;
  wire [NCLIENT-1:0]    ok_w;
  wire [32*NCLIENT-1:0] dout_w;

  assign inhibit = downloading | loop_rst;
  assign busy    = (state_q == ST_WAIT);
  // An access that saw downloading/loop_rst while in flight must not fill.
  assign fill    = busy && (timer_q == T_LATCH) && read_req_q && !abort_q && !inhibit;

  // Round-robin pick: first missing client at or after ptr_q.
  always_comb begin
    sel      = ptr_q;
    any_miss = 1'b0;
    rr_idx   = '0;
    for (int k = NCLIENT - 1; k >= 0; k--) begin
      rr_idx = CW'((int'(ptr_q) + k) % NCLIENT);
      if (miss_w[rr_idx]) begin
        sel      = rr_idx;
        any_miss = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    ptr_d        = ptr_q;
    cur_d        = cur_q;
    read_sync_d  = read_sync_q;
    read_req_d   = read_req_q;
    sdram_addr_d = sdram_addr_q;
    abort_d      = abort_q;
    case (state_q)
      ST_IDLE: begin
        if (timer_q == '0 && !inhibit) begin
          read_sync_d = ~read_sync_q;
          timer_d     = T_LOAD;
          state_d     = ST_WAIT;
          abort_d     = 1'b0;
          read_req_d  = any_miss;
          if (any_miss) begin
            cur_d        = sel;
            sdram_addr_d = bus.cl_addr[22*int'(sel) +: 22];
            ptr_d        = CW'((int'(sel) + 1) % NCLIENT);
          end
        end
      end
      ST_WAIT: begin
        if (inhibit) begin
          abort_d = 1'b1;
        end
        timer_d = timer_q - TW'(1);
        if (timer_q == TW'(1)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      ptr_q        <= '0;
      cur_q        <= '0;
      read_sync_q  <= 1'b0;
      read_req_q   <= 1'b0;
      sdram_addr_q <= '0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      ptr_q        <= ptr_d;
      cur_q        <= cur_d;
      read_sync_q  <= read_sync_d;
      read_req_q   <= read_req_d;
      sdram_addr_q <= sdram_addr_d;
      abort_q      <= abort_d;
    end
  end

  for (genvar gi = 0; gi < NCLIENT; gi++) begin : g_client
    logic [21:0] tag_q, tag_d;
    logic [31:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic        ok_q, ok_d;
    logic [21:0] addr;
    logic        hit;
    logic        mine;

    assign addr = bus.cl_addr[22*gi +: 22];
    assign mine = (cur_q == CW'(gi));
    assign hit  = valid_q && (tag_q == addr);

    always_comb begin
      tag_d   = tag_q;
      data_d  = data_q;
      valid_d = valid_q;
      ok_d    = bus.cl_cs[gi] && hit;
      if (inhibit) begin
        valid_d = 1'b0;
      end else if (fill && mine) begin
        tag_d   = sdram_addr_q;
        data_d  = bus.data_read;
        valid_d = 1'b1;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        tag_q   <= '0;
        data_q  <= '0;
        valid_q <= 1'b0;
        ok_q    <= 1'b0;
      end else begin
        tag_q   <= tag_d;
        data_q  <= data_d;
        valid_q <= valid_d;
        ok_q    <= ok_d;
      end
    end

    // The client being served is not a miss, so it cannot be picked twice.
    assign miss_w[gi]          = bus.cl_cs[gi] && !hit && !(busy && mine);
    assign ok_w[gi]            = ok_q;
    assign dout_w[32*gi +: 32] = data_q;
  end

  assign bus.cl_ok      = ok_w;
  assign bus.cl_dout    = dout_w;
  assign bus.read_sync  = read_sync_q;
  assign bus.read_req   = read_req_q;
  assign bus.sdram_addr = sdram_addr_q;

endmodule

// File: tb/tb_jtgng_rom_arbiter.sv
// Scoreboard bench for jtgng_rom_arbiter: an SDRAM model answers reads LAT cycles after each
// toggle, expected accesses are queued as stimulus is applied and popped at each read strobe.
`timescale 1ns/1ps
module tb_jtgng_rom_arbiter;
  localparam int NCLIENT = 4;
  localparam int LAT     = 9;
  localparam int PERIOD  = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic loop_rst = 1'b1;
  logic downloading = 1'b0;

  always #5 clk = ~clk;

  jtgng_rom_arbiter_if #(.NCLIENT(NCLIENT)) bus ();

  jtgng_rom_arbiter #(
    .NCLIENT (NCLIENT),
    .LAT     (LAT),
    .PERIOD  (PERIOD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .loop_rst    (loop_rst),
    .downloading (downloading),
    .bus         (bus.master)
  );

  typedef struct {
    int          cl;
    logic [21:0] addr;
    bit          ok;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   tog_cyc[$];
  bit   tog_req[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem(input logic [21:0] a);
    if (a == 22'h01234) return 32'hCAFEBABE;
    return {a[9:0], a} ^ 32'h5A5A1234;
  endfunction

  // SDRAM model and read monitor
  logic        sync_seen = 1'b0;
  int          cd = -1;
  logic [21:0] cap_addr;
  logic        cap_req;
  int          pcnt = -1;
  int          pcl = 0;
  logic [21:0] paddr;
  bit          pok;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    bus.data_read = 32'h0BAD0BAD;
    if (rst) begin
      sync_seen = 1'b0;
      cd        = -1;
      pcnt      = -1;
    end else begin
      if (pcnt > 0) begin
        pcnt--;
        if (pcnt == 1) begin
          check($sformatf("ok_before_fill_cl%0d", pcl), bus.cl_ok[pcl], 1'b0);
        end else if (pcnt == 0) begin
          check($sformatf("ok_after_fill_cl%0d", pcl), bus.cl_ok[pcl], pok);
          if (pok) check($sformatf("dout_cl%0d", pcl), bus.cl_dout[32*pcl +: 32], mem(paddr));
          pcnt = -1;
        end
      end
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          check("addr_stable", bus.sdram_addr, cap_addr);
          check("req_stable", bus.read_req, cap_req);
          if (cap_req) bus.data_read = mem(cap_addr);
        end
      end
      if (bus.read_sync !== sync_seen) begin
        sync_seen = bus.read_sync;
        cap_addr  = bus.sdram_addr;
        cap_req   = bus.read_req;
        cd        = LAT - 1;
        tog_cyc.push_back(cyc);
        tog_req.push_back(bus.read_req);
        $display("toggle cyc=%0d req=%0b addr=%06h", cyc, bus.read_req, bus.sdram_addr);
        if (bus.read_req) begin
          check("sb_pending", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check($sformatf("rd_addr_cl%0d", mon_e.cl), bus.sdram_addr, mon_e.addr);
            pcnt  = LAT + 1;
            pcl   = mon_e.cl;
            paddr = mon_e.addr;
            pok   = mon_e.ok;
          end
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_tog(input int target, input int budget, input string tag);
    int b = 0;
    while (tog_cyc.size() < target && b < budget) begin
      step();
      b++;
    end
    if (tog_cyc.size() < target) check(tag, tog_cyc.size(), target);
  endtask

  task automatic wait_pop(input int budget, input string tag);
    int b = 0;
    while (exp_q.size() != 0 && b < budget) begin
      step();
      b++;
    end
    if (exp_q.size() != 0) check(tag, exp_q.size(), 0);
  endtask

  task automatic wait_drain(input int budget, input string tag);
    int b = 0;
    while ((exp_q.size() != 0 || pcnt >= 0) && b < budget) begin
      step();
      b++;
    end
    if (exp_q.size() != 0 || pcnt >= 0) check(tag, (exp_q.size() == 0 && pcnt < 0), 1'b1);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int n;
    int rel;
    bus.cl_cs   = '0;
    bus.cl_addr = '0;
    repeat (3) step();
    check("rst_read_sync", bus.read_sync, 1'b0);
    check("rst_read_req", bus.read_req, 1'b0);
    check("rst_sdram_addr", bus.sdram_addr, 22'h0);
    check("rst_cl_ok", bus.cl_ok, 4'h0);
    check("rst_cl_dout", bus.cl_dout, 128'h0);

    // Controller still initialising: no strobes
    rst = 1'b0;
    n = tog_cyc.size();
    repeat (100) step();
    check("loop_rst_no_toggle", tog_cyc.size(), n);
    check("loop_rst_sync_low", bus.read_sync, 1'b0);

    // Idle refreshes every PERIOD
    loop_rst = 1'b0;
    rel = cyc;
    s = tog_cyc.size();
    wait_tog(s + 3, 40, "refresh_timeout");
    if (tog_cyc.size() >= s + 3) begin
      check("refresh_first", tog_cyc[s], rel + 1);
      for (int i = 0; i < 3; i++) check("refresh_req", tog_req[s+i], 1'b0);
      for (int i = 0; i < 2; i++) check("refresh_gap", tog_cyc[s+i+1] - tog_cyc[s+i], PERIOD);
    end

    // Single client read
    exp_q.push_back('{2, 22'h01234, 1'b1});
    bus.cl_addr[22*2 +: 22] = 22'h01234;
    bus.cl_cs[2] = 1'b1;
    wait_drain(40, "c2_drain");
    repeat (25) step();
    check("c2_ok_hold", bus.cl_ok, 4'b0100);
    check("c2_dout_hold", bus.cl_dout[32*2 +: 32], 32'hCAFEBABE);

    // Asynchronous reset in the middle of a read access
    exp_q.push_back('{0, 22'h3ABCD, 1'b1});
    bus.cl_addr[0 +: 22] = 22'h3ABCD;
    bus.cl_cs[0] = 1'b1;
    wait_pop(30, "c0_pop");
    repeat (3) step();
    check("pre_rst_req", bus.read_req, 1'b1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_read_sync", bus.read_sync, 1'b0);
    check("arst_read_req", bus.read_req, 1'b0);
    check("arst_sdram_addr", bus.sdram_addr, 22'h0);
    check("arst_cl_ok", bus.cl_ok, 4'h0);
    check("arst_cl_dout", bus.cl_dout, 128'h0);
    bus.cl_cs = '0;
    step();
    step();
    rst = 1'b0;
    rel = cyc;
    s = tog_cyc.size();
    wait_tog(s + 1, 5, "post_rst_timeout");
    if (tog_cyc.size() > s) begin
      check("post_rst_refresh", tog_req[s], 1'b0);
      check("post_rst_time", tog_cyc[s], rel + 1);
    end

    // All four clients miss together with ptr at 0
    s = tog_cyc.size();
    for (int i = 0; i < NCLIENT; i++) begin
      bus.cl_addr[22*i +: 22] = 22'h00100 * 22'(i + 1);
      exp_q.push_back('{i, 22'h00100 * 22'(i + 1), 1'b1});
    end
    bus.cl_cs = 4'hF;
    wait_drain(80, "rr_drain");
    if (tog_cyc.size() >= s + 4) begin
      for (int i = 0; i < 4; i++) check("rr_req", tog_req[s+i], 1'b1);
      for (int i = 0; i < 3; i++) check("rr_gap", tog_cyc[s+i+1] - tog_cyc[s+i], PERIOD);
    end else begin
      check("rr_toggles", tog_cyc.size(), s + 4);
    end
    step();
    check("rr_all_ok", bus.cl_ok, 4'hF);

    // Address change while the access is in flight
    bus.cl_cs = 4'b0010;
    bus.cl_addr[22*1 +: 22] = 22'h00010;
    exp_q.push_back('{1, 22'h00010, 1'b0});
    wait_pop(30, "chg_pop");
    repeat (3) step();
    bus.cl_addr[22*1 +: 22] = 22'h00020;
    exp_q.push_back('{1, 22'h00020, 1'b1});
    wait_drain(60, "chg_drain");
    step();
    check("chg_ok", bus.cl_ok, 4'b0010);
    check("chg_dout", bus.cl_dout[32*1 +: 32], mem(22'h00020));

    // Downloading pulse invalidates and blocks strobes
    s = tog_cyc.size();
    wait_tog(s + 1, 20, "dl_sync_timeout");
    step();
    downloading = 1'b1;
    exp_q.push_back('{1, 22'h00020, 1'b1});
    n = tog_cyc.size();
    repeat (2) step();
    check("dl_ok_drop", bus.cl_ok, 4'h0);
    repeat (3) step();
    downloading = 1'b0;
    check("dl_no_toggle", tog_cyc.size(), n);
    wait_drain(40, "dl_drain");
    step();
    check("dl_reread_ok", bus.cl_ok, 4'b0010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
